// File: rtl/contador_pkg.sv
// Shared types for the parameterised up/down counter.
//   mode_t  : count behaviour at the terminal value (wrap, saturate, one-shot)
//   state_t : counter control state (counting, or parked after a one-shot)
package contador_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10
    } mode_t;

    typedef enum logic {
        COUNT = 1'b0,
        DONE  = 1'b1
    } state_t;

endpackage : contador_pkg

// File: rtl/contador_param.sv
// Parameterised up/down counter with wrap, saturate and one-shot modes.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : synchronous clear (q, ovf, state)
//   load      : synchronous load of load_val (clamped to MAX)
//   en, up    : count enable and direction (1 = increment)
//   mode      : behaviour at the terminal value
//   q         : registered count, never above MAX
//   tc        : combinational strobe, high in the cycle before a terminal edge
//   ovf       : registered sticky overflow/underflow flag
//   done      : registered one-shot completion flag (state == DONE)
module contador_param
    import contador_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned MAX   = (2 ** WIDTH) - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    input  mode_t            mode,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf,
    output logic             done
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             ovf_nxt;
    logic             terminal;

    // Terminal case depends only on direction and the current count.
    assign terminal = up ? (q == MAX_Q) : (q == '0);

    assign tc   = en & ~clr & ~load & (state == COUNT) & terminal;
    assign done = (state == DONE);

    // Next-state logic: clr > load > en, at most one action per edge.
    always_comb begin
        q_nxt     = q;
        ovf_nxt   = ovf;
        state_nxt = state;
        if (clr) begin
            q_nxt     = '0;
            ovf_nxt   = 1'b0;
            state_nxt = COUNT;
        end else if (load) begin
            q_nxt     = (load_val > MAX_Q) ? MAX_Q : load_val;
            state_nxt = COUNT;
        end else if (en && (state == COUNT)) begin
            if (!terminal) begin
                q_nxt = up ? (q + WIDTH'(1)) : (q - WIDTH'(1));
            end else begin
                case (mode)
                    MODE_SAT: begin
                        ovf_nxt = 1'b1;
                    end
                    MODE_ONESHOT: begin
                        state_nxt = DONE;
                    end
                    // MODE_WRAP and the reserved encoding both wrap.
                    default: begin
                        q_nxt   = up ? '0 : MAX_Q;
                        ovf_nxt = 1'b1;
                    end
                endcase
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q     <= '0;
            ovf   <= 1'b0;
            state <= COUNT;
        end else begin
            q     <= q_nxt;
            ovf   <= ovf_nxt;
            state <= state_nxt;
        end
    end

endmodule : contador_param

// File: tb/tb_contador_param.sv
// Directed table-driven bench for contador_param (WIDTH=4, MAX=9) plus a
// default-width instance for the down-wrap from zero.
module tb_contador_param;
    import contador_pkg::*;

    logic       clk = 1'b0;
    logic       rst, clr, load, en, up;
    logic [3:0] load_val;
    mode_t      mode;
    logic [3:0] q;
    logic       tc, ovf, done;

    logic       rst8, clr8, load8, en8, up8;
    logic [7:0] load_val8;
    mode_t      mode8;
    logic [7:0] q8;
    logic       tc8, ovf8, done8;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    contador_param #(.WIDTH(4), .MAX(9)) dut (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up(up), .mode(mode), .q(q), .tc(tc), .ovf(ovf), .done(done)
    );

    contador_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .clr(clr8), .load(load8), .load_val(load_val8),
        .en(en8), .up(up8), .mode(mode8), .q(q8), .tc(tc8), .ovf(ovf8), .done(done8)
    );

    typedef struct {
        string      name;
        logic       clr;
        logic       load;
        logic [3:0] lv;
        logic       en;
        logic       up;
        logic [1:0] mode;
        logic       tc;     // expected before the edge
        logic [3:0] q;      // expected after the edge
        logic       ovf;
        logic       done;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic c, logic l, logic [3:0] lv,
                                logic e, logic u, logic [1:0] m, logic t,
                                logic [3:0] eq, logic eo, logic ed);
        vec_t v;
        v.name = name; v.clr = c; v.load = l; v.lv = lv; v.en = e; v.up = u;
        v.mode = m; v.tc = t; v.q = eq; v.ovf = eo; v.done = ed;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(vec_t v);
        @(negedge clk);
        clr = v.clr; load = v.load; load_val = v.lv; en = v.en; up = v.up;
        mode = mode_t'(v.mode);
        #1 check({v.name, ".tc"}, 32'(tc), 32'(v.tc));
        @(posedge clk);
        #1;
        check({v.name, ".q"},    32'(q),    32'(v.q));
        check({v.name, ".ovf"},  32'(ovf),  32'(v.ovf));
        check({v.name, ".done"}, 32'(done), 32'(v.done));
    endtask

    initial begin
        // Wrap: 1..9 then 0, tc only while q=9.
        for (int i = 1; i <= 9; i++)
            vecs.push_back(mk("wrap_up", 0, 0, 0, 1, 1, 2'b00, 0, 4'(i), 0, 0));
        vecs.push_back(mk("wrap_edge", 0, 0, 0, 1, 1, 2'b00, 1, 4'd0, 1, 0));
        vecs.push_back(mk("clr",       1, 0, 0, 0, 1, 2'b00, 0, 4'd0, 0, 0));
        // Saturate down from 2.
        vecs.push_back(mk("sat_load",  0, 1, 2, 0, 0, 2'b01, 0, 4'd2, 0, 0));
        vecs.push_back(mk("sat_dn1",   0, 0, 0, 1, 0, 2'b01, 0, 4'd1, 0, 0));
        vecs.push_back(mk("sat_dn0",   0, 0, 0, 1, 0, 2'b01, 0, 4'd0, 0, 0));
        vecs.push_back(mk("sat_hold1", 0, 0, 0, 1, 0, 2'b01, 1, 4'd0, 1, 0));
        vecs.push_back(mk("sat_hold2", 0, 0, 0, 1, 0, 2'b01, 1, 4'd0, 1, 0));
        vecs.push_back(mk("en_off",    0, 0, 0, 0, 0, 2'b01, 0, 4'd0, 1, 0));
        // One-shot from 7; load leaves ovf set.
        vecs.push_back(mk("os_load",   0, 1, 7, 0, 1, 2'b10, 0, 4'd7, 1, 0));
        vecs.push_back(mk("os_8",      0, 0, 0, 1, 1, 2'b10, 0, 4'd8, 1, 0));
        vecs.push_back(mk("os_9",      0, 0, 0, 1, 1, 2'b10, 0, 4'd9, 1, 0));
        vecs.push_back(mk("os_done",   0, 0, 0, 1, 1, 2'b10, 1, 4'd9, 1, 1));
        vecs.push_back(mk("os_ign1",   0, 0, 0, 1, 1, 2'b10, 0, 4'd9, 1, 1));
        vecs.push_back(mk("os_ign2",   0, 0, 0, 1, 1, 2'b10, 0, 4'd9, 1, 1));
        vecs.push_back(mk("os_modechg",0, 0, 0, 1, 0, 2'b00, 0, 4'd9, 1, 1));
        vecs.push_back(mk("os_reload", 0, 1, 3, 0, 1, 2'b10, 0, 4'd3, 1, 0));
        // Priority and clamp.
        vecs.push_back(mk("prio_all",  1, 1, 5, 1, 1, 2'b00, 0, 4'd0, 0, 0));
        vecs.push_back(mk("clamp15",   0, 1, 15, 0, 1, 2'b00, 0, 4'd9, 0, 0));
        vecs.push_back(mk("rsvd_wrap", 0, 0, 0, 1, 1, 2'b11, 1, 4'd0, 1, 0));
        vecs.push_back(mk("dn_wrap",   0, 0, 0, 1, 0, 2'b00, 1, 4'd9, 1, 0));
        vecs.push_back(mk("load_max",  0, 1, 9, 0, 1, 2'b00, 0, 4'd9, 1, 0));
        vecs.push_back(mk("load_vs_en",0, 1, 4, 1, 1, 2'b00, 0, 4'd4, 1, 0));
        vecs.push_back(mk("load5",     0, 1, 5, 0, 1, 2'b00, 0, 4'd5, 1, 0));

        rst = 1'b1; clr = 0; load = 0; load_val = 0; en = 0; up = 1; mode = MODE_WRAP;
        rst8 = 1'b1; clr8 = 0; load8 = 0; load_val8 = 0; en8 = 0; up8 = 0; mode8 = MODE_WRAP;
        #2;
        check("reset.q",    32'(q),    32'd0);
        check("reset.ovf",  32'(ovf),  32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.tc",   32'(tc),   32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rst8 = 1'b0;

        foreach (vecs[i]) apply(vecs[i]);

        // Async reset between edges at q=5, ovf=1, with pending load/en.
        @(negedge clk);
        load = 1'b1; load_val = 4'd7; en = 1'b1; up = 1'b1; mode = MODE_WRAP;
        rst = 1'b1;
        #1;
        check("arst.q_now",   32'(q),    32'd0);
        check("arst.ovf_now", 32'(ovf),  32'd0);
        @(posedge clk);
        #1 check("arst.q_edge", 32'(q), 32'd0);
        @(negedge clk);
        rst = 1'b0; load = 1'b0;
        @(posedge clk);
        #1 check("arst.resume", 32'(q), 32'd1);

        // Reset clears DONE.
        @(negedge clk);
        load = 1'b1; load_val = 4'd9; en = 1'b0; mode = MODE_ONESHOT;
        @(negedge clk);
        load = 1'b0; en = 1'b1;
        @(negedge clk);
        check("arst_done.pre", 32'(done), 32'd1);
        rst = 1'b1;
        #1 check("arst_done.post", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0; en = 1'b0;

        // Default width: down from 0 wraps to 255.
        @(negedge clk);
        en8 = 1'b1; up8 = 1'b0; mode8 = MODE_WRAP;
        #1 check("w8.tc", 32'(tc8), 32'd1);
        @(posedge clk);
        #1;
        check("w8.q",   32'(q8),   32'd255);
        check("w8.ovf", 32'(ovf8), 32'd1);
        @(negedge clk);
        en8 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_contador_param
